// File: rtl/peripheral_timer_bank_if.sv
// Word-access peripheral bus (A/WD/WE/RD) shared by the I/O, display and timer blocks.
// The master drives address, write data and write enable; the slave returns read data.
interface peripheral_timer_bank_if #(
  parameter int A_W = 7
);
  logic [A_W-1:0] A;
  logic [31:0]    WD;
  logic           WE;
  logic [31:0]    RD;

  modport master (output A, output WD, output WE, input RD);
  modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/peripheral_timer_bank.sv
// Bank of N_CH timer/PWM channels behind one shared prescaler.
// Each channel raises a pending flag per period event; masked flags are ORed into irq.
module peripheral_timer_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 16,
  parameter int A_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  peripheral_timer_bank_if.slave bus,
  output logic [N_CH-1:0]        pwm,
  output logic                   irq
);

  localparam int GRP_W = A_W - 4;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PWM      = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  ie;
  mode_e            mode    [N_CH];
  logic [CNT_W-1:0] period  [N_CH];
  logic [CNT_W-1:0] compare [N_CH];
  logic [CNT_W-1:0] count   [N_CH];

  // Decode: group 0 holds PRESCALE/STATUS, group c+1 holds channel c.
  logic [GRP_W-1:0] grp;
  logic [1:0]       reg_sel;
  logic             pre_wr;
  logic             tick;
  logic [N_CH-1:0]  stat_clr;
  logic [N_CH-1:0]  ch_sel;
  logic [N_CH-1:0]  ctrl_wr, per_wr, cmp_wr, cnt_wr;
  logic [N_CH-1:0]  ev;
  logic [31:0]      rd_data;

  assign grp     = bus.A[A_W-1:4];
  assign reg_sel = bus.A[3:2];

  // Byte lanes below word alignment and WD bits above each field are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.A[1:0], bus.WD};

  // NOTE: every variable driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pre_wr   = bus.WE && (grp == '0) && (reg_sel == 2'd0);
    stat_clr = (bus.WE && (grp == '0) && (reg_sel == 2'd1)) ? bus.WD[N_CH-1:0] : '0;
    tick     = (pre_cnt == prescale) && !pre_wr;
    ch_sel   = '0;
    ctrl_wr  = '0;
    per_wr   = '0;
    cmp_wr   = '0;
    cnt_wr   = '0;
    ev       = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_sel[c]  = (grp == GRP_W'(c + 1));
      ctrl_wr[c] = bus.WE && ch_sel[c] && (reg_sel == 2'd0);
      per_wr[c]  = bus.WE && ch_sel[c] && (reg_sel == 2'd1);
      cmp_wr[c]  = bus.WE && ch_sel[c] && (reg_sel == 2'd2);
      cnt_wr[c]  = bus.WE && ch_sel[c] && (reg_sel == 2'd3);
      // >= rather than == so a PERIOD written below COUNT still terminates on the next tick.
      ev[c] = tick && en[c] && (count[c] >= period[c]) && !cnt_wr[c];
    end
  end

  always_comb begin
    rd_data = '0;
    if (grp == '0) begin
      if (reg_sel == 2'd0) rd_data[PRE_W-1:0] = prescale;
      if (reg_sel == 2'd1) rd_data[N_CH-1:0]  = pending;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          2'd0:    rd_data[3:0]       = {ie[c], mode[c], en[c]};
          2'd1:    rd_data[CNT_W-1:0] = period[c];
          2'd2:    rd_data[CNT_W-1:0] = compare[c];
          default: rd_data[CNT_W-1:0] = count[c];
        endcase
      end
    end
  end

  assign bus.RD = rd_data;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale <= '0;
      pre_cnt  <= '0;
      pending  <= '0;
      en       <= '0;
      ie       <= '0;
      pwm      <= '0;
      irq      <= 1'b0;
      // NOTE: the per-channel arrays are plain flops, not RAM, so they are reset explicitly.
      for (int c = 0; c < N_CH; c++) begin
        mode[c]    <= MODE_PERIODIC;
        period[c]  <= '0;
        compare[c] <= '0;
        count[c]   <= '0;
      end
    end else begin
      if (pre_wr) begin
        prescale <= bus.WD[PRE_W-1:0];
        pre_cnt  <= '0;
      end else if (tick) begin
        pre_cnt  <= '0;
      end else begin
        pre_cnt  <= pre_cnt + 1'b1;
      end

      // Set beats clear when an event and a W1C hit the same bit.
      pending <= (pending & ~stat_clr) | ev;
      irq     <= |(pending & ie);

      for (int c = 0; c < N_CH; c++) begin
        pwm[c] <= en[c] && (mode[c] == MODE_PWM) && (count[c] < compare[c]);

        if (ctrl_wr[c]) begin
          en[c]   <= bus.WD[0];
          mode[c] <= mode_e'(bus.WD[2:1]);
          ie[c]   <= bus.WD[3];
        end else if (ev[c] && (mode[c] == MODE_ONESHOT)) begin
          en[c]   <= 1'b0;
        end

        if (per_wr[c]) period[c]  <= bus.WD[CNT_W-1:0];
        if (cmp_wr[c]) compare[c] <= bus.WD[CNT_W-1:0];

        if (cnt_wr[c]) begin
          count[c] <= bus.WD[CNT_W-1:0];
        end else if (ctrl_wr[c] && bus.WD[4]) begin
          count[c] <= '0;
        end else if (ev[c]) begin
          if (mode[c] != MODE_ONESHOT) count[c] <= '0;
        end else if (tick && en[c]) begin
          count[c] <= count[c] + 1'b1;
        end
      end
    end
  end

endmodule
